// File: rtl/freq_meter.sv
// Counts synchronized rising edges of signal_i over a GATE_CYCLES window and reports the count.
// Latency: an input edge reaches the counter SYNC_STAGES+1 cycles later; the result registers 1 cycle after the window ends.
// No backpressure: valid_o is a one-cycle strobe and windows run back to back while enable_i is high.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int COUNT_WIDTH = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   signal_i,
    input  logic                   enable_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   valid_o,
    output logic                   overflow_o,
    output logic                   busy_o
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]          GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    state_t                 state_q, state_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [COUNT_WIDTH-1:0] edge_q, edge_d, edge_step;
    logic                   sat_q, sat_d, sat_step;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   valid_d;
    logic                   overflow_d;

    // Synchronizer chain and edge register; runs in every state so edges are tracked across IDLE.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Saturating edge increment; a rise arriving while already at the ceiling marks the window as overflowed.
    always_comb begin
        edge_step = edge_q;
        sat_step  = sat_q;
        if (rise) begin
            if (edge_q == CNT_MAX) begin
                sat_step = 1'b1;
            end else begin
                edge_step = edge_q + 1'b1;
            end
        end
    end

    // Next-state and output logic for the IDLE/MEASURE window controller.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        sat_d      = sat_q;
        count_d    = count_o;
        overflow_d = overflow_o;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = MEASURE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (gate_q == GATE_LAST) begin
                    // Final gate cycle: publish including this cycle's rise, then restart or stop.
                    count_d    = edge_step;
                    overflow_d = sat_step;
                    valid_d    = 1'b1;
                    gate_d     = '0;
                    edge_d     = '0;
                    sat_d      = 1'b0;
                    state_d    = enable_i ? MEASURE : IDLE;
                end else if (!enable_i) begin
                    // Abort: partial window is discarded, published result is left untouched.
                    state_d = IDLE;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = edge_step;
                    sat_d  = sat_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            edge_q     <= '0;
            sat_q      <= 1'b0;
            count_o    <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            sat_q      <= sat_d;
            count_o    <= count_d;
            valid_o    <= valid_d;
            overflow_o <= overflow_d;
        end
    end

    assign busy_o = (state_q == MEASURE);

endmodule
